// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM decimator: 2-FF input synchronizer, CIC_ORDER integrators
// running at the PDM strobe rate, a pipelined comb section (one stage per
// clk) at the decimated rate, and a valid/ready output register with a
// sticky overrun flag. Integrator and comb arithmetic wraps modulo 2^W.
module pdm_cic_decimator #(
  parameter int  CIC_ORDER = 4,
  parameter int  DECIM     = 64,
  parameter int  OUT_WIDTH = 16,
  localparam int ACC_WIDTH = CIC_ORDER * $clog2(DECIM) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pdm_strobe,
  input  logic                 pdm_data,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int W      = ACC_WIDTH;
  localparam int CNT_W  = $clog2(DECIM);
  localparam int DISC_W = $clog2(CIC_ORDER + 1);
  localparam int SHIFT  = W - OUT_WIDTH;

  // Input synchronizer
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Integrators and decimation counter
  logic [CIC_ORDER-1:0][W-1:0] integ_q, integ_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Comb pipeline: stage 0 holds the latched I_N, stage k the output of comb k
  logic [CIC_ORDER:0][W-1:0]   stage_q, stage_d;
  logic [CIC_ORDER:0]          vld_q, vld_d;
  logic [CIC_ORDER-1:0][W-1:0] dly_q, dly_d;

  // Output side
  logic [DISC_W-1:0]    discard_q, discard_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;

  logic                 accept;
  logic                 decim_hit;
  logic [W-1:0]         x_ext;
  logic                 finish;
  logic                 keep;
  logic [OUT_WIDTH-1:0] scaled;
  logic                 unused_lsbs;

  // A strobe is only taken while capture is enabled; bit 1 -> +1, bit 0 -> -1.
  assign accept    = en & pdm_strobe;
  assign x_ext     = sync2_q ? W'(1) : {W{1'b1}};
  assign decim_hit = accept && (cnt_q == CNT_W'(DECIM - 1));

  // The last comb output is complete; scaling is an arithmetic shift whose
  // kept bits are exactly the top OUT_WIDTH bits, so the low bits are dropped.
  assign finish      = vld_q[CIC_ORDER];
  assign keep        = finish && (discard_q == '0);
  assign scaled      = stage_q[CIC_ORDER][W-1:SHIFT];
  assign unused_lsbs = ^stage_q[CIC_ORDER][SHIFT-1:0];

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  // Front end: synchronizer, integrator chain (each stage adds the previous
  // stage's registered value) and the decimation counter.
  always_comb begin
    sync1_d = pdm_data;
    sync2_d = sync1_q;
    integ_d = integ_q;
    cnt_d   = cnt_q;
    if (accept) begin
      integ_d[0] = integ_q[0] + x_ext;
      for (int k = 1; k < CIC_ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!en) begin
      integ_d = '0;
      cnt_d   = '0;
    end
  end

  // Comb pipeline: latch I_N on the decimating strobe, then one comb per clk.
  always_comb begin
    stage_d = stage_q;
    vld_d   = '0;
    dly_d   = dly_q;
    if (decim_hit) begin
      stage_d[0] = integ_d[CIC_ORDER-1];
      vld_d[0]   = 1'b1;
    end
    for (int k = 1; k <= CIC_ORDER; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        stage_d[k]   = stage_q[k-1] - dly_q[k-1];
        dly_d[k-1]   = stage_q[k-1];
      end
    end
    if (!en) begin
      stage_d = '0;
      vld_d   = '0;
      dly_d   = '0;
    end
  end

  // Output register, settling discard, handshake and sticky overrun.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    discard_d   = discard_q;
    if (finish && (discard_q != '0)) begin
      discard_d = discard_q - DISC_W'(1);
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (keep) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = scaled;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (!en) begin
      discard_d = DISC_W'(CIC_ORDER);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      integ_q     <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      vld_q       <= '0;
      dly_q       <= '0;
      discard_q   <= DISC_W'(CIC_ORDER);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      integ_q     <= integ_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      vld_q       <= vld_d;
      dly_q       <= dly_d;
      discard_q   <= discard_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator. The reference computes each PCM
// sample as the convolution of the +/-1 input history with the CIC impulse
// response (box filter of length DECIM convolved CIC_ORDER times), delayed
// by the integrator chain, then scaled by an arithmetic shift.
module tb_pdm_cic_decimator;

  localparam int N     = 4;
  localparam int R     = 64;
  localparam int OW    = 16;
  localparam int W     = N * $clog2(R) + 2;
  localparam int SHIFT = W - OW;
  localparam int HLEN  = N * (R - 1) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pdm_strobe;
  logic          pdm_data;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          overrun_clr;

  int            total = 0;
  int            bad   = 0;
  longint        h [HLEN];
  int            xs [$];
  logic [OW-1:0] exp_q [$];
  int            ready_mode;
  bit            hold_mode;
  bit            hold_pushed;
  int            accepted = 0;
  logic [OW-1:0] last_out = '0;
  bit            valid_seen;
  bit            alt_bit = 1'b0;

  pdm_cic_decimator #(
    .CIC_ORDER (N),
    .DECIM     (R),
    .OUT_WIDTH (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pdm_strobe  (pdm_strobe),
    .pdm_data    (pdm_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_h();
    longint cur[];
    longint nxt[];
    cur    = new[1];
    cur[0] = 1;
    for (int s = 0; s < N; s++) begin
      nxt = new[cur.size() + R - 1];
      foreach (nxt[i]) nxt[i] = 0;
      for (int i = 0; i < cur.size(); i++)
        for (int j = 0; j < R; j++)
          nxt[i+j] += cur[i];
      cur = nxt;
    end
    for (int i = 0; i < HLEN; i++) h[i] = cur[i];
  endtask

  // Expected PCM value for the decimating strobe at history index n.
  function automatic logic [OW-1:0] model_sample(input int n);
    longint              y;
    logic signed [W-1:0] yw;
    logic signed [W-1:0] ys;
    y = 0;
    for (int j = 0; j < HLEN; j++) begin
      int idx;
      idx = n - (N - 1) - j;
      if (idx >= 0) y += h[j] * longint'(xs[idx]);
    end
    yw = y[W-1:0];
    ys = yw >>> SHIFT;
    return ys[OW-1:0];
  endfunction

  // One PDM bit: present data, let it cross the synchronizer, then strobe.
  task automatic do_strobe(input bit b, input int gap);
    pdm_data = b;
    repeat (gap) tick();
    pdm_strobe = 1'b1;
    tick();
    pdm_strobe = 1'b0;
    if (en) begin
      xs.push_back(b ? 1 : -1);
      if (xs.size() % R == 0 && (xs.size() / R - 1) >= N) begin
        if (!hold_mode || !hold_pushed) begin
          exp_q.push_back(model_sample(xs.size() - 1));
          if (hold_mode) hold_pushed = 1'b1;
        end
      end
    end
  endtask

  // mode 0: zeros, 1: ones, 2: alternating, 3: random density per period
  task automatic run_periods(input int p, input int mode);
    for (int q = 0; q < p; q++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < R; i++) begin
        bit b;
        case (mode)
          0:       b = 1'b0;
          1:       b = 1'b1;
          2:       begin alt_bit = ~alt_bit; b = alt_bit; end
          default: b = ($urandom_range(0, 99) < dens);
        endcase
        do_strobe(b, $urandom_range(2, 4));
      end
    end
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'(($urandom_range(0, 1)));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted sample, checks holding.
  initial begin
    bit            hs;
    logic [OW-1:0] hd;
    logic [OW-1:0] e;
    hs = 1'b0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs = 1'b0;
      end else begin
        if (out_valid) valid_seen = 1'b1;
        if (hs) begin
          check("hold_valid", 64'(out_valid), 1);
          check("hold_data", $signed(out_data), $signed(hd));
        end
        if (out_valid && !out_ready) begin
          hs = 1'b1;
          hd = out_data;
        end else begin
          hs = 1'b0;
        end
        if (out_valid && out_ready) begin
          accepted++;
          last_out = out_data;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_sample: got %0d, expected no sample", $signed(out_data));
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              bad++;
              $display("FAIL sample: got %0d, expected %0d", $signed(out_data), $signed(e));
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int n;
    build_h();
    rst         = 1'b1;
    en          = 1'b1;
    pdm_strobe  = 1'b0;
    pdm_data    = 1'b0;
    overrun_clr = 1'b0;
    ready_mode  = 1;
    out_ready   = 1'b1;
    hold_mode   = 1'b0;
    hold_pushed = 1'b0;
    valid_seen  = 1'b0;
    repeat (4) tick();
    check("reset_valid", 64'(out_valid), 0);
    check("reset_data", $signed(out_data), 0);
    check("reset_overrun", 64'(overrun), 0);
    rst = 1'b0;
    tick();

    // DC +1: four settling samples dropped, then full-scale positive
    a0 = accepted;
    run_periods(8, 1);
    repeat (10) tick();
    check("dc_plus_count", accepted - a0, 4);
    check("dc_plus_value", $signed(last_out), 16384);

    // DC -1, then alternating pattern
    run_periods(6, 0);
    repeat (10) tick();
    check("dc_minus_value", $signed(last_out), -16384);
    run_periods(6, 2);
    repeat (10) tick();
    check("alt_value", $signed(last_out), 0);

    // Latency from decimating strobe to out_valid
    for (int i = 0; i < R - 1; i++) do_strobe(1'b1, 3);
    do_strobe(1'b1, 3);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, N + 1);
    repeat (5) tick();

    // Backpressure: first sample held, later ones dropped with overrun
    ready_mode  = 0;
    hold_mode   = 1'b1;
    hold_pushed = 1'b0;
    for (int i = 0; i < R; i++) do_strobe(1'b1, 3);
    repeat (8) tick();
    check("ovr_before_drop", 64'(overrun), 0);
    check("ovr_held_valid", 64'(out_valid), 1);
    for (int i = 0; i < 2 * R; i++) do_strobe(1'b1, 3);
    repeat (8) tick();
    check("ovr_set", 64'(overrun), 1);
    check("ovr_still_valid", 64'(out_valid), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_cleared", 64'(overrun), 0);
    hold_mode  = 1'b0;
    ready_mode = 1;
    repeat (5) tick();
    check("held_sample_drained", exp_q.size(), 0);

    // Capture disabled: strobes ignored, settling discard on re-enable
    repeat (10) tick();
    en = 1'b0;
    tick();
    valid_seen = 1'b0;
    for (int i = 0; i < 100; i++) do_strobe(1'($urandom_range(0, 1)), 2);
    check("no_valid_while_idle", 64'(valid_seen), 0);
    en = 1'b1;
    xs.delete();
    a0 = accepted;
    run_periods(6, 1);
    repeat (10) tick();
    check("reen_count", accepted - a0, 2);
    check("reen_value", $signed(last_out), 16384);
    check("reen_no_overrun", 64'(overrun), 0);

    // Reset with a sample pending
    ready_mode = 0;
    run_periods(1, 1);
    repeat (8) tick();
    check("pending_valid", 64'(out_valid), 1);
    for (int i = 0; i < 20; i++) do_strobe(1'b1, 2);
    rst = 1'b1;
    tick();
    check("rst_valid", 64'(out_valid), 0);
    check("rst_data", $signed(out_data), 0);
    check("rst_overrun", 64'(overrun), 0);
    rst = 1'b0;
    exp_q.delete();
    xs.delete();
    ready_mode = 1;
    a0 = accepted;
    run_periods(6, 1);
    repeat (10) tick();
    check("post_rst_count", accepted - a0, 2);
    check("post_rst_value", $signed(last_out), 16384);

    // Long random run with random backpressure
    ready_mode = 2;
    run_periods(30, 3);
    ready_mode = 1;
    repeat (20) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
